// File: rtl/usart_tx_arbiter_if.sv
// Requester and USART TX-writer signal bundle for usart_tx_arbiter.
// master = arbiter side, slave = requesters plus USART side.
interface usart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MSG_LENGTH = 48
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*MSG_LENGTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_grant;
   logic [NUM_REQ-1:0]            req_done;
   logic                          tx_ready;
   logic                          tx_valid;
   logic [MSG_LENGTH-1:0]         tx_data;
   logic                          busy;
   logic                          timeout_err;

   modport master (
      input  req_valid, req_data, tx_ready,
      output req_grant, req_done, tx_valid, tx_data, busy, timeout_err
   );

   modport slave (
      output req_valid, req_data, tx_ready,
      input  req_grant, req_done, tx_valid, tx_data, busy, timeout_err
   );
endinterface

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART TX writer between NUM_REQ requesters.
// Optional watchdog abort compiled in with `define USART_TX_ARB_WATCHDOG_EN.
module usart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned MSG_LENGTH     = 48,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                clk,
   input logic                rsnt,
   usart_tx_arbiter_if.master bus
);
   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SEND      = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic                    tx_valid_q, tx_valid_d;
   logic [MSG_LENGTH-1:0]   tx_data_q, tx_data_d;
   logic                    busy_q, busy_d;
   logic [PTR_W-1:0]        last_ptr_q, last_ptr_d;
   logic [PTR_W-1:0]        owner_q, owner_d;

   logic                    win_found_c;
   logic [PTR_W-1:0]        win_idx_c;
   logic [PTR_W-1:0]        scan_idx_c;

`ifdef USART_TX_ARB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_err_q, timeout_err_d;
   logic            wd_expired_c;

   // Abort lands on the edge the counter would reach TIMEOUT_CYCLES.
   assign wd_expired_c = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   // First pending requester after the last owner wins.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      scan_idx_c  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         scan_idx_c = PTR_W'((32'(last_ptr_q) + k) % NUM_REQ);
         if (!win_found_c && bus.req_valid[scan_idx_c]) begin
            win_found_c = 1'b1;
            win_idx_c   = scan_idx_c;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = '0;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      busy_d     = busy_q;
      last_ptr_d = last_ptr_q;
      owner_d    = owner_q;
`ifdef USART_TX_ARB_WATCHDOG_EN
      timeout_err_d = 1'b0;
      wd_cnt_d      = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.tx_ready && win_found_c) begin
               state_d    = ST_SEND;
               grant_d    = NUM_REQ'(1) << win_idx_c;
               tx_data_d  = bus.req_data[32'(win_idx_c)*MSG_LENGTH +: MSG_LENGTH];
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
               owner_d    = win_idx_c;
            end
         end
         ST_SEND: begin
            // Ready dropping means the USART has taken the frame.
            if (!bus.tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.tx_ready) begin
               state_d    = ST_IDLE;
               grant_d    = '0;
               done_d     = NUM_REQ'(1) << owner_q;
               last_ptr_d = owner_q;
               busy_d     = 1'b0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            busy_d     = 1'b0;
         end
      endcase

`ifdef USART_TX_ARB_WATCHDOG_EN
      // A normal handshake step on the same edge takes precedence over the abort.
      if (wd_expired_c && (state_d == state_q) &&
          ((state_q == ST_SEND) || (state_q == ST_WAIT_DONE))) begin
         state_d       = ST_IDLE;
         grant_d       = '0;
         tx_valid_d    = 1'b0;
         done_d        = NUM_REQ'(1) << owner_q;
         last_ptr_d    = owner_q;
         busy_d        = 1'b0;
         timeout_err_d = 1'b1;
      end

      if ((state_d == state_q) &&
          ((state_q == ST_SEND) || (state_q == ST_WAIT_DONE))) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
`endif
   end

   always_ff @(posedge clk or negedge rsnt) begin
      if (!rsnt) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         last_ptr_q <= PTR_W'(NUM_REQ - 1);
         owner_q    <= '0;
`ifdef USART_TX_ARB_WATCHDOG_EN
         timeout_err_q <= 1'b0;
         wd_cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         last_ptr_q <= last_ptr_d;
         owner_q    <= owner_d;
`ifdef USART_TX_ARB_WATCHDOG_EN
         timeout_err_q <= timeout_err_d;
         wd_cnt_q      <= wd_cnt_d;
`endif
      end
   end

   assign bus.req_grant = grant_q;
   assign bus.req_done  = done_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.busy      = busy_q;
`ifdef USART_TX_ARB_WATCHDOG_EN
   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Scoreboard bench for usart_tx_arbiter: requester and USART models are stepped
// each cycle; expected grants/payloads/dones are queued at stimulus time.
module tb_usart_tx_arbiter;
   localparam int unsigned NR = 4;
   localparam int unsigned MW = 48;
   localparam int unsigned TO = 16;

   logic clk;
   logic rsnt;

   usart_tx_arbiter_if #(.NUM_REQ(NR), .MSG_LENGTH(MW)) bif ();

   usart_tx_arbiter #(
      .NUM_REQ(NR), .MSG_LENGTH(MW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .rsnt (rsnt),
      .bus  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [MW-1:0] pay_q [NR][$];
   logic [MW-1:0] exp_data [$];
   logic [NR-1:0] exp_grant [$];
   logic [NR-1:0] exp_done [$];

   bit            usart_en;
   int            us_st, us_cnt, drop_dly, hold_dly, exp_vlen;
   bit            prev_valid, in_txn, exp_to;
   int            vlen;
   logic [MW-1:0] cur_exp;
   logic [NR-1:0] cur_grant;
   bit            scr_en [NR];
   logic [MW-1:0] scr_val;

   task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic set_usart(int drop, int hold);
      drop_dly = drop;
      hold_dly = hold;
      exp_vlen = drop + 1;
   endtask

   // Output-side scoreboard, sampled 1 time unit after the rising edge.
   task automatic monitor_step();
      if (bif.tx_valid && !prev_valid) begin
         vlen = 1;
         check_eq("tx_expected", 64'(exp_data.size() != 0), 64'(1));
         if (exp_data.size() != 0) begin
            cur_exp   = exp_data.pop_front();
            cur_grant = exp_grant.pop_front();
            in_txn    = 1'b1;
            check_eq("tx_data", 64'(bif.tx_data), 64'(cur_exp));
            check_eq("grant", 64'(bif.req_grant), 64'(cur_grant));
            check_eq("busy", 64'(bif.busy), 64'(1));
         end
      end else if (bif.tx_valid) begin
         vlen++;
         check_eq("tx_data_hold", 64'(bif.tx_data), 64'(cur_exp));
      end else if (prev_valid) begin
         check_eq("valid_len", 64'(vlen), 64'(exp_vlen));
      end
      if (in_txn && bif.req_done == '0)
         check_eq("grant_hold", 64'(bif.req_grant), 64'(cur_grant));
      if (bif.req_done != '0) begin
         if (exp_done.size() == 0) begin
            check_eq("unexpected_done", 64'(bif.req_done), 64'(0));
         end else begin
            check_eq("done", 64'(bif.req_done), 64'(exp_done.pop_front()));
            check_eq("grant_clear", 64'(bif.req_grant), 64'(0));
            check_eq("busy_idle", 64'(bif.busy), 64'(0));
            check_eq("timeout_err", 64'(bif.timeout_err), 64'(exp_to));
         end
         in_txn = 1'b0;
      end
      prev_valid = bif.tx_valid;
   endtask

   // Requesters and USART drive their next inputs.
   task automatic model_step();
      for (int i = 0; i < int'(NR); i++) begin
         if (bif.req_grant[i] && bif.req_valid[i]) begin
            bif.req_valid[i] = 1'b0;
            if (scr_en[i]) bif.req_data[i*MW +: MW] = scr_val;
         end else if (!bif.req_valid[i] && !bif.req_grant[i] && pay_q[i].size() != 0) begin
            bif.req_data[i*MW +: MW] = pay_q[i].pop_front();
            bif.req_valid[i]         = 1'b1;
         end
      end
      case (us_st)
         0: if (usart_en && bif.tx_valid) begin
               us_cnt = drop_dly;
               us_st  = 1;
            end
         1: begin
               us_cnt--;
               if (us_cnt <= 0) begin
                  bif.tx_ready = 1'b0;
                  us_cnt       = hold_dly;
                  us_st        = 2;
               end
            end
         default: begin
               us_cnt--;
               if (us_cnt <= 0) begin
                  bif.tx_ready = 1'b1;
                  us_st        = 0;
               end
            end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      monitor_step();
      model_step();
   endtask

   task automatic run_until_done(int budget);
      int n = 0;
      while ((exp_done.size() != 0 || exp_data.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_in_time", 64'(exp_done.size() + exp_data.size()), 64'(0));
      repeat (3) tick();
   endtask

   // One-cycle low pulse on rsnt; outputs must clear without waiting for a clock.
   task automatic do_reset();
      rsnt = 1'b0;
      #1;
      check_eq("rst_grant", 64'(bif.req_grant), 64'(0));
      check_eq("rst_done", 64'(bif.req_done), 64'(0));
      check_eq("rst_valid", 64'(bif.tx_valid), 64'(0));
      check_eq("rst_data", 64'(bif.tx_data), 64'(0));
      check_eq("rst_busy", 64'(bif.busy), 64'(0));
      check_eq("rst_timeout", 64'(bif.timeout_err), 64'(0));
      bif.req_valid = '0;
      bif.req_data  = '0;
      bif.tx_ready  = 1'b1;
      usart_en      = 1'b1;
      us_st         = 0;
      prev_valid    = 1'b0;
      in_txn        = 1'b0;
      exp_to        = 1'b0;
      for (int i = 0; i < int'(NR); i++) begin
         pay_q[i].delete();
         scr_en[i] = 1'b0;
      end
      exp_data.delete();
      exp_grant.delete();
      exp_done.delete();
      @(posedge clk);
      #1;
      rsnt = 1'b1;
   endtask

   task automatic expect_txn(int r, logic [MW-1:0] d);
      exp_grant.push_back(NR'(1) << r);
      exp_data.push_back(d);
      exp_done.push_back(NR'(1) << r);
   endtask

   initial begin
      rsnt = 1'b1;
      #2;
      do_reset();

      // Single requester, ready drops 2 cycles after valid and returns 10 later.
      set_usart(1, 10);
      pay_q[0].push_back(48'hA5A5_0000_0001);
      expect_txn(0, 48'hA5A5_0000_0001);
      run_until_done(60);

      // All four pending, each re-requesting once: strict rotation from 0.
      do_reset();
      set_usart(2, 3);
      for (int i = 0; i < int'(NR); i++) begin
         pay_q[i].push_back(MW'(i + 1));
         pay_q[i].push_back(MW'(i + 1));
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < int'(NR); i++) expect_txn(i, MW'(i + 1));
      run_until_done(400);

      // No grant while the USART is not ready.
      usart_en     = 1'b0;
      bif.tx_ready = 1'b0;
      pay_q[2].push_back(48'h0000_2222_0002);
      repeat (5) begin
         tick();
         check_eq("no_grant_busy_usart", 64'({bif.req_grant, bif.tx_valid, bif.busy}), 64'(0));
      end
      expect_txn(2, 48'h0000_2222_0002);
      bif.tx_ready = 1'b1;
      usart_en     = 1'b1;
      tick();
      check_eq("grant_after_ready", 64'(bif.req_grant), 64'(4'b0100));
      run_until_done(60);

      // Payload changed after grant must not reach tx_data.
      set_usart(1, 4);
      scr_en[1] = 1'b1;
      scr_val   = 48'h0000_0000_FF00;
      pay_q[1].push_back(48'h0000_0000_00FF);
      expect_txn(1, 48'h0000_0000_00FF);
      run_until_done(60);
      check_eq("tx_data_keep", 64'(bif.tx_data), 64'(48'h00FF));
      scr_en[1] = 1'b0;

      // Reset while waiting for completion: no done, pointer back to requester 0.
      set_usart(1, 20);
      pay_q[1].push_back(48'h55);
      exp_grant.push_back(4'b0010);
      exp_data.push_back(48'h55);
      for (int n = 0; n < 50 && us_st != 2; n++) tick();
      check_eq("reached_wait_done", 64'(us_st), 64'(2));
      repeat (3) tick();
      do_reset();
      set_usart(1, 2);
      pay_q[0].push_back(48'h77);
      pay_q[3].push_back(48'h88);
      expect_txn(0, 48'h77);
      expect_txn(3, 48'h88);
      run_until_done(100);

      // USART never accepts the frame.
      usart_en = 1'b0;
      pay_q[2].push_back(48'h99);
      exp_grant.push_back(4'b0100);
      exp_data.push_back(48'h99);
`ifdef USART_TX_ARB_WATCHDOG_EN
      exp_done.push_back(4'b0100);
      exp_to   = 1'b1;
      exp_vlen = int'(TO);
      run_until_done(60);
      check_eq("wd_valid_low", 64'(bif.tx_valid), 64'(0));
      check_eq("wd_idle", 64'(bif.busy), 64'(0));
`else
      repeat (40) begin
         tick();
         check_eq("no_timeout", 64'(bif.timeout_err), 64'(0));
      end
      check_eq("stuck_valid", 64'(bif.tx_valid), 64'(1));
      check_eq("stuck_busy", 64'(bif.busy), 64'(1));
`endif

      check_eq("exp_left", 64'(exp_data.size() + exp_done.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
